// File: rtl/load_store_unit_if.sv
// Execute-side request, memory bus and response signals of the load/store unit.
// The slave modport is the unit; the master modport is the execute stage plus memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, opcode, funct3, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
           rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, opcode, funct3, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
           rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, alignment/legality checking,
// store lane replication with byte strobes, and load extraction with extension.
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        f3_legal;
  logic        misaligned;
  logic        req_err;
  logic [3:0]  strb_new;
  logic [31:0] lane_new;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] maddr_q;
  logic [3:0]  strb_q;
  logic [31:0] mwdata_q;
  logic [31:0] rdata_q;

  // Request decode on the live inputs; only consumed on the accept edge.
  always_comb begin
    is_load  = (bus.opcode == 7'b0000011);
    is_store = (bus.opcode == 7'b0100011);
    f3_legal = 1'b0;
    if (is_load)
      f3_legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (is_store)
      f3_legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    req_err    = !f3_legal || misaligned;
    case (bus.funct3[1:0])
      2'b00: begin
        strb_new = 4'b0001 << bus.addr[1:0];
        lane_new = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        strb_new = 4'b0011 << bus.addr[1:0];
        lane_new = {2{bus.wdata[15:0]}};
      end
      default: begin
        strb_new = 4'b1111;
        lane_new = bus.wdata;
      end
    endcase
    accept = bus.req_valid && bus.req_ready;
  end

  always_comb begin
    case (off_q)
      2'd0:    sel_byte = bus.mem_rdata[7:0];
      2'd1:    sel_byte = bus.mem_rdata[15:8];
      2'd2:    sel_byte = bus.mem_rdata[23:16];
      default: sel_byte = bus.mem_rdata[31:24];
    endcase
    sel_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = req_err ? DONE : REQ;
      REQ:  if (bus.mem_ready) state_next = we_q ? DONE : WAIT;
      WAIT: if (bus.mem_rvalid) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Memory payload is fully formed at accept so it stays frozen through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      err_q    <= 1'b0;
      maddr_q  <= '0;
      strb_q   <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      we_q     <= is_store;
      f3_q     <= bus.funct3;
      off_q    <= bus.addr[1:0];
      err_q    <= req_err;
      maddr_q  <= {bus.addr[31:2], 2'b00};
      strb_q   <= is_store ? strb_new : '0;
      mwdata_q <= is_store ? lane_new : '0;
      rdata_q  <= '0;
    end else if ((state == WAIT) && bus.mem_rvalid) begin
      rdata_q  <= load_ext;
    end
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.busy      = (state != IDLE);
    bus.mem_valid = (state == REQ);
    bus.mem_we    = (state == REQ) && we_q;
    bus.mem_addr  = maddr_q;
    bus.mem_wstrb = strb_q;
    bus.mem_wdata = mwdata_q;
    bus.rsp_valid = (state == DONE);
    bus.rsp_data  = rdata_q;
    bus.rsp_err   = err_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: spec-level model checked every busy cycle,
// plus literal expectations, latency, stall-hold and reset-abandon scenarios.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if b ();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(b.slave));

  typedef struct {
    logic        err;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rsp;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    logic [31:0] lit_rsp;
    logic        lit_err;
    bit          mlit;
    logic [31:0] lit_maddr;
    logic [3:0]  lit_strb;
    logic [31:0] lit_mwdata;
  } vec_t;

  int   n_vec  = 0;
  int   n_fail = 0;
  bit   active = 1'b0;
  exp_t cur;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: byte lanes, sizes and extension expressed as arithmetic.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t e;
    int unsigned size = 1 << f3[1:0];
    int unsigned off  = a % 4;
    bit ld = (op == 7'h03);
    bit st = (op == 7'h23);
    bit legal;
    longint unsigned v;
    longint unsigned span;
    legal   = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (st ? (f3 <= 3'd2) : 1'b0);
    e.err   = !legal || ((size > 1) && ((a % size) != 0));
    e.we    = st;
    e.maddr = a - off;
    e.strb  = '0;
    e.wdata = '0;
    e.rsp   = '0;
    if (!e.err && st)
      for (int i = 0; i < 4; i++) begin
        e.strb[i] = (i >= off) && (i < off + size);
        e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
    if (!e.err && ld) begin
      v = 64'(rd >> (8 * off));
      if (size < 4) begin
        span = 64'd1 << (8 * size);
        v = v % span;
        if (!f3[2] && (v >= span / 2)) v = v + 64'h1_0000_0000 - span;
      end
      e.rsp = v[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (active) begin
      chk("busy_during_txn", {31'd0, b.busy}, 32'd1);
      chk("req_ready_during_txn", {31'd0, b.req_ready}, 32'd0);
      if (b.mem_valid) begin
        chk("mem_valid_only_legal", {31'd0, b.mem_valid}, {31'd0, !cur.err});
        chk("mem_we", {31'd0, b.mem_we}, {31'd0, cur.we});
        chk("mem_addr", b.mem_addr, cur.maddr);
        chk("mem_wstrb", {28'd0, b.mem_wstrb}, {28'd0, cur.strb});
        chk("mem_wdata", b.mem_wdata, cur.wdata);
      end
      if (b.rsp_valid) begin
        chk("rsp_err", {31'd0, b.rsp_err}, {31'd0, cur.err});
        chk("rsp_data", b.rsp_data, cur.rsp);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, {31'd0, b.mem_valid}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, b.mem_we}, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, b.mem_wstrb}, 32'd0);
    chk({tag, "_mem_addr"}, b.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, b.mem_wdata, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, b.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, b.rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, b.rsp_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, b.busy}, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, b.req_ready}, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   stall = v.stall;
    int   lat = 0;
    int   exp_lat;
    bit   hs = 0, hs_pending = 0, rv_sent = 0, seen_rsp = 0, saw_mem = 0;
    logic [31:0] got_rsp = '0, got_maddr = '0, got_mwdata = '0;
    logic [3:0]  got_strb = '0;
    logic        got_err = 1'b0;
    e = model(v.op, v.f3, v.a, v.wd, v.rd);
    exp_lat = e.err ? 1 : ((e.we ? 2 : 3) + v.stall);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, b.req_ready}, 32'd1);
    cur         = e;
    b.req_valid = 1'b1;
    b.opcode    = v.op;
    b.funct3    = v.f3;
    b.addr      = v.a;
    b.wdata     = v.wd;
    b.mem_ready = (stall == 0);
    @(posedge clk);
    #1;
    b.req_valid = 1'b0;
    b.opcode    = 7'h7F;
    b.funct3    = 3'd7;
    b.addr      = $urandom;
    b.wdata     = $urandom;
    active      = 1'b1;
    for (int c = 1; c <= 60 && !seen_rsp; c++) begin
      @(negedge clk);
      if (hs_pending) begin
        hs = 1; hs_pending = 0; b.mem_ready = 1'b0;
      end
      if (hs && !e.we && !rv_sent) begin
        b.mem_rvalid = 1'b1; b.mem_rdata = v.rd; rv_sent = 1;
      end else begin
        b.mem_rvalid = 1'b0; b.mem_rdata = $urandom;
      end
      if (b.mem_valid && !hs) begin
        if (!saw_mem) begin
          got_maddr = b.mem_addr; got_strb = b.mem_wstrb; got_mwdata = b.mem_wdata;
        end
        saw_mem = 1;
        if (stall > 0) begin
          b.mem_ready = 1'b0; stall--;
        end else begin
          b.mem_ready = 1'b1; hs_pending = 1;
        end
      end
      if (b.rsp_valid) begin
        seen_rsp = 1; lat = c; got_rsp = b.rsp_data; got_err = b.rsp_err;
      end
    end
    chk("rsp_seen", {31'd0, seen_rsp}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("mem_accessed", {31'd0, saw_mem}, {31'd0, !e.err});
    chk("rsp_data_literal", got_rsp, v.lit_rsp);
    chk("rsp_err_literal", {31'd0, got_err}, {31'd0, v.lit_err});
    if (v.mlit) begin
      chk("mem_addr_literal", got_maddr, v.lit_maddr);
      chk("mem_wstrb_literal", {28'd0, got_strb}, {28'd0, v.lit_strb});
      chk("mem_wdata_literal", got_mwdata, v.lit_mwdata);
    end
    @(posedge clk);
    #1;
    active       = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_ready  = 1'b0;
    @(negedge clk);
    chk("rsp_single_pulse", {31'd0, b.rsp_valid}, 32'd0);
    chk("back_to_idle", {31'd0, b.req_ready}, 32'd1);
  endtask

  initial begin
    b.req_valid  = 1'b0;
    b.opcode     = '0;
    b.funct3     = '0;
    b.addr       = '0;
    b.wdata      = '0;
    b.mem_ready  = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_rdata  = '0;

    //             op     f3    addr          wdata         rdata         stall lit_rsp       err  mlit maddr         strb     mwdata
    vecs.push_back('{7'h23, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,        0, 32'h0,        1'b0, 1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD});
    vecs.push_back('{7'h03, 3'd0, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 32'hFFFF_FF80, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd4, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 32'h0000_0080, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd1, 32'h0000_2002, 32'h0,        32'h9ABC_0000, 0, 32'hFFFF_9ABC, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd2, 32'h0000_2000, 32'h0,        32'h9ABC_0000, 0, 32'h9ABC_0000, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd2, 32'h0000_2002, 32'h0,        32'h9ABC_0000, 0, 32'h0,        1'b1, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h23, 3'd2, 32'h0000_3000, 32'h1122_3344, 32'h0,        5, 32'h0,        1'b0, 1, 32'h0000_3000, 4'b1111, 32'h1122_3344});
    vecs.push_back('{7'h23, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        0, 32'h0,        1'b0, 1, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF});
    vecs.push_back('{7'h03, 3'd5, 32'h0000_2002, 32'h0,        32'h9ABC_0000, 0, 32'h0000_9ABC, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd0, 32'h0000_2003, 32'h0,        32'h7F00_0000, 2, 32'h0000_007F, 1'b0, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h23, 3'd1, 32'h0000_1001, 32'h5555_5555, 32'h0,        0, 32'h0,        1'b1, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h03, 3'd3, 32'h0000_2000, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,        1'b1, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h23, 3'd4, 32'h0000_2000, 32'h0,        32'h0,        0, 32'h0,        1'b1, 0, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{7'h33, 3'd0, 32'h0000_2000, 32'h0,        32'h0,        0, 32'h0,        1'b1, 0, 32'h0, 4'h0, 32'h0});

    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in WAIT: transaction dropped, late rvalid ignored.
    @(negedge clk);
    b.req_valid = 1'b1; b.opcode = 7'h03; b.funct3 = 3'd2; b.addr = 32'h2000; b.mem_ready = 1'b1;
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    @(negedge clk);
    chk("wait_setup_mem_valid", {31'd0, b.mem_valid}, 32'd1);
    @(negedge clk);
    b.mem_ready = 1'b0;
    chk("wait_setup_busy", {31'd0, b.busy}, 32'd1);
    chk("wait_setup_no_mem_valid", {31'd0, b.mem_valid}, 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset_in_wait");
    @(posedge clk);
    #1 chk("reset_no_rsp", {31'd0, b.rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    b.mem_rvalid = 1'b1;
    b.mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 b.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_rvalid_no_rsp", {31'd0, b.rsp_valid}, 32'd0);
      chk("stray_rvalid_idle", {31'd0, b.busy}, 32'd0);
      chk("stray_rvalid_rsp_data", b.rsp_data, 32'd0);
    end
    run_txn(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents a LOAD/STORE
- req_ready  out  1  unit can accept a request
- opcode  in  7  0000011 = LOAD, 0100011 = STORE
- funct3  in  3  access size/sign (RV32I encoding)
- addr  in  32  effective address (rs1+imm from execute)
- wdata  in  32  store data (rs2)
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access; qualified by rsp_valid
- busy  out  1  state != IDLE

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-003 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready at a clock edge.
REQ-004 On acceptance, the unit SHALL register opcode, funct3, addr and wdata; a later change on those inputs SHALL NOT affect the transaction.
REQ-005 An accepted request SHALL go directly to DONE with rsp_err=1 and no memory access when any of these holds:
- halfword with addr[0]=1
- word with addr[1:0]!=00
- LOAD funct3 not in {000,001,010,100,101}
- STORE funct3 not in {000,001,010}
- opcode is neither LOAD nor STORE
REQ-006 A legal request SHALL go to REQ; mem_valid=1 from the next cycle and SHALL stay 1, with mem_we/mem_addr/mem_wstrb/mem_wdata stable, until mem_valid & mem_ready.
REQ-007 Store strobes SHALL be:
- SB: 0001<<addr[1:0]
- SH: 0011<<addr[1:0]
- SW: 1111
REQ-008 Store data SHALL be:
- mem_wdata = {4{wdata[7:0]}} for SB
- mem_wdata = {2{wdata[15:0]}} for SH
- mem_wdata = wdata for SW
REQ-009 Loads SHALL drive mem_wstrb=0000 and mem_we=0.
REQ-010 After the request handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-011 In WAIT, the unit SHALL sample mem_rvalid every cycle; on mem_rvalid=1 it SHALL capture mem_rdata and go to DONE.
REQ-012 mem_rvalid outside WAIT SHALL be ignored.
REQ-013 Load extraction SHALL select byte addr[1:0] or halfword addr[1], then extend:
- LB/LH: sign-extend
- LBU/LHU: zero-extend
- LW: full word
REQ-014 In DONE, rsp_valid SHALL be 1 for exactly one cycle, with rsp_data/rsp_err valid; the FSM then SHALL return to IDLE.
REQ-015 Minimum latency from acceptance edge to rsp_valid:
- error: 1 cycle
- store with mem_ready already high: 2 cycles
- load with mem_ready high and mem_rvalid one cycle after the handshake: 3 cycles
REQ-016 There SHALL be no timeout; the unit waits indefinitely in REQ or WAIT.
REQ-017 rsp_valid, rsp_data, rsp_err, mem_valid and mem_we SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-018 While rst=1, the unit SHALL immediately be in IDLE, independent of clk, with these output values:
- mem_valid=0, mem_we=0, mem_wstrb=0000
- mem_addr=0, mem_wdata=0
- rsp_valid=0, rsp_data=0, rsp_err=0
- busy=0
- req_ready=0 while rst held
REQ-019 Reset asserted in REQ or WAIT SHALL abandon the transaction with no rsp_valid.
REQ-020 A mem_rvalid arriving after reset release SHALL be ignored.
REQ-021 The first request SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- SB addr=0x1003 wdata=0xAABBCCDD, mem_ready=1 -> mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD; rsp_valid 2 cycles after accept, rsp_err=0.
- LB addr=0x2001, mem_rdata=0x12348056 -> rsp_data=0xFFFFFF80; LBU same -> 0x00000080.
- LH addr=0x2002, mem_rdata=0x9ABC0000 -> rsp_data=0xFFFF9ABC; LW addr=0x2000 -> 0x9ABC0000.
- LW addr=0x2002 -> no mem_valid, rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0.
- SW with mem_ready low 5 cycles -> mem_valid and payload held constant 5 cycles, req_ready=0 throughout; completes after the handshake.
- LW, rst pulsed in WAIT, then mem_rvalid=1 -> outputs reset immediately, no rsp_valid, stray rvalid ignored, next request accepted normally.
